// File: rtl/wdt_supervisor_mc.sv
// Multi-channel watchdog supervisor: per-channel feed monitor with timed reset pulses and lock-out.
// Optional windowed mode (premature feeds count as faults) is enabled by defining WDT_WINDOW_EN.
module wdt_supervisor_mc #(
    parameter int NCH       = 32'd4,
    parameter int CNT_W     = 32'd16,
    parameter int TIMEOUT   = 32'd20000,
    parameter int GRACE_CYC = 32'd40000,
    parameter int RST_PULSE = 32'd2000,
    parameter int MAX_RETRY = 32'd3,
    parameter int WIN_MIN   = 32'd1000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [NCH-1:0] i_en,
    input  logic [NCH-1:0] i_wdi,
    input  logic [NCH-1:0] i_clr,
    output logic [NCH-1:0] o_rst_n,
    output logic [NCH-1:0] o_err,
    output logic [NCH-1:0] o_lock,
    output logic           o_any_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRACE  = 3'd1,
        ST_RUN    = 3'd2,
        ST_PULSE  = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] GRACE_LAST = CNT_W'(GRACE_CYC - 32'd1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE - 32'd1);
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_MIN - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [3:0]       RETRY_LIM  = 4'(MAX_RETRY);

`ifdef WDT_WINDOW_EN
    localparam logic WIN_ENABLE = 1'b1;
`else
    localparam logic WIN_ENABLE = 1'b0;
`endif

    logic [NCH-1:0] sync1_r, sync2_r, sync3_r, feed_r;
    logic           any_err_r;

    // Feed synchronizer and edge detector; feed_r pulses once per wdi transition.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_r   <= {NCH{1'b0}};
            sync2_r   <= {NCH{1'b0}};
            sync3_r   <= {NCH{1'b0}};
            feed_r    <= {NCH{1'b0}};
            any_err_r <= 1'b0;
        end else begin
            sync1_r   <= i_wdi;
            sync2_r   <= sync1_r;
            sync3_r   <= sync2_r;
            feed_r    <= sync2_r ^ sync3_r;
            any_err_r <= |o_err;
        end
    end

    assign o_any_err = any_err_r;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t           state_r, state_nxt_s;
        logic [CNT_W-1:0] timer_r, timer_nxt_s, timer_inc_s;
        logic [3:0]       retry_r, retry_nxt_s, retry_base_s, retry_tmo_s;
        logic             err_r, err_nxt_s, lock_r, rst_n_r, tmo_s, premature_s;

        assign timer_inc_s  = (timer_r == CNT_MAX) ? timer_r : timer_r + CNT_W'(1'b1);
        assign retry_base_s = i_clr[g] ? 4'd0 : retry_r;
        assign retry_tmo_s  = (retry_base_s == 4'hF) ? 4'hF : retry_base_s + 4'd1;
        assign premature_s  = WIN_ENABLE & (timer_r < WIN_LAST);

        // Next-state logic; a clear on a timeout cycle still yields err=1, retry=1.
        always_comb begin
            state_nxt_s = state_r;
            timer_nxt_s = timer_inc_s;
            retry_nxt_s = retry_base_s;
            err_nxt_s   = err_r & ~i_clr[g];
            tmo_s       = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    timer_nxt_s = CNT_ZERO;
                    if (i_en[g]) begin
                        state_nxt_s = ST_GRACE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_GRACE: begin
                    if (!i_en[g]) begin
                        state_nxt_s = ST_IDLE;
                        timer_nxt_s = CNT_ZERO;
                    end else if (feed_r[g]) begin
                        state_nxt_s = ST_RUN;
                        timer_nxt_s = CNT_ZERO;
                    end else if (timer_r == GRACE_LAST) begin
                        tmo_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_GRACE;
                    end
                end
                ST_RUN: begin
                    if (!i_en[g]) begin
                        state_nxt_s = ST_IDLE;
                        timer_nxt_s = CNT_ZERO;
                    end else if (feed_r[g] && premature_s) begin
                        tmo_s = 1'b1;
                    end else if (feed_r[g]) begin
                        timer_nxt_s = CNT_ZERO;
                        retry_nxt_s = 4'd0;
                    end else if (timer_r == TMO_LAST) begin
                        tmo_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_PULSE: begin
                    if (!i_en[g]) begin
                        state_nxt_s = ST_IDLE;
                        timer_nxt_s = CNT_ZERO;
                    end else if (timer_r == PULSE_LAST) begin
                        state_nxt_s = ST_GRACE;
                        timer_nxt_s = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_PULSE;
                    end
                end
                ST_LOCKED: begin
                    timer_nxt_s = CNT_ZERO;
                    if (i_clr[g]) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_LOCKED;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    timer_nxt_s = CNT_ZERO;
                end
            endcase
            if (tmo_s) begin
                err_nxt_s   = 1'b1;
                retry_nxt_s = retry_tmo_s;
                timer_nxt_s = CNT_ZERO;
                if (retry_tmo_s == RETRY_LIM) begin
                    state_nxt_s = ST_LOCKED;
                end else begin
                    state_nxt_s = ST_PULSE;
                end
            end else begin
                retry_nxt_s = retry_nxt_s;
            end
        end

        // Channel state and registered outputs, derived from the next state so they move with it.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                state_r <= ST_IDLE;
                timer_r <= CNT_ZERO;
                retry_r <= 4'd0;
                err_r   <= 1'b0;
                lock_r  <= 1'b0;
                rst_n_r <= 1'b1;
            end else begin
                state_r <= state_nxt_s;
                timer_r <= timer_nxt_s;
                retry_r <= retry_nxt_s;
                err_r   <= err_nxt_s;
                lock_r  <= (state_nxt_s == ST_LOCKED);
                rst_n_r <= ~((state_nxt_s == ST_PULSE) || (state_nxt_s == ST_LOCKED));
            end
        end

        assign o_rst_n[g] = rst_n_r;
        assign o_err[g]   = err_r;
        assign o_lock[g]  = lock_r;
    end

endmodule
